// File: rtl/extmem_pkg.sv
// Shared types and helpers for the external parity RAM arbiter
// and the memory front ends that sit on top of it.
package extmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    P0,
    P1,
    SCRUB
  } owner_t;

  // Odd parity over each 9-bit byte.
  function automatic logic parity_good(input logic [17:0] w);
    return (^w[17:9]) & (^w[8:0]);
  endfunction

endpackage

// File: rtl/extmem_scrubber.sv
// Idle-time parity scrubber: idle counter, scrub pointer and
// parity-error count/address bookkeeping.
module extmem_scrubber #(
  parameter int AW         = 17,
  parameter int SCRUB_IDLE = 64
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          scrub_en,
  input  logic          quiet,
  input  logic          grant,
  input  logic          rd_done,
  input  logic          scrub_done,
  input  logic [AW-1:0] rd_addr,
  input  logic [17:0]   rd_data,
  input  logic          perr_clr,
  output logic          scrub_go,
  output logic [AW-1:0] scrub_addr,
  output logic [15:0]   perr_count,
  output logic [AW-1:0] perr_addr
);
  import extmem_pkg::*;

  localparam logic [7:0] IDLE_MAX = 8'(SCRUB_IDLE);

  logic [7:0]    idle_q, idle_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] eaddr_q, eaddr_d;

  assign scrub_go   = quiet && scrub_en && idle_q == IDLE_MAX;
  assign scrub_addr = ptr_q;
  assign perr_count = cnt_q;
  assign perr_addr  = eaddr_q;

  always_comb begin
    idle_d  = idle_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    if (grant)
      idle_d = '0;
    else if (quiet && scrub_en && idle_q != IDLE_MAX)
      idle_d = idle_q + 8'd1;
    if (scrub_done)
      ptr_d = ptr_q + 1'b1;
    // A clear in the same cycle as an error wins.
    if (perr_clr) begin
      cnt_d   = '0;
      eaddr_d = '0;
    end else if (rd_done && !parity_good(rd_data)) begin
      if (cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
      eaddr_d = rd_addr;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      idle_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
    end else begin
      idle_q  <= idle_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
    end
  end

endmodule

// File: rtl/extmem_arbiter.sv
// Two-port arbiter with background scrubbing in front of the
// single-port 18-bit parity block RAM.
module extmem_arbiter #(
  parameter int AW         = 17,
  parameter int LAT        = 2,
  parameter int STARVE     = 4,
  parameter int SCRUB_IDLE = 64
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  input  logic [1:0]    r0_wena,
  input  logic [17:0]   r0_wdata,
  output logic          r0_ack,
  output logic [17:0]   r0_rdata,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  input  logic [1:0]    r1_wena,
  input  logic [17:0]   r1_wdata,
  output logic          r1_ack,
  output logic [17:0]   r1_rdata,
  input  logic          scrub_en,
  output logic [15:0]   perr_count,
  output logic [AW-1:0] perr_addr,
  input  logic          perr_clr,
  output logic [AW-1:0] extmemaddr,
  output logic [17:0]   extmemdout,
  input  logic [17:0]   extmemdin,
  output logic          extmemenab,
  output logic [1:0]    extmemwena
);
  import extmem_pkg::*;

  localparam int         SW   = $clog2(STARVE + 1);
  localparam logic [2:0] LAST = 3'(LAT - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [17:0]   dout_q, dout_d;
  logic [1:0]    wena_q, wena_d;
  logic          enab_q, enab_d;
  logic [17:0]   rd0_q, rd0_d;
  logic [17:0]   rd1_q, rd1_d;

  logic          any_req, quiet, grant, last;
  logic          rd_done, scrub_done, scrub_go;
  logic [AW-1:0] scrub_addr;

  assign any_req    = r0_req | r1_req;
  assign quiet      = state_q == IDLE && !any_req;
  assign grant      = state_q == IDLE && (any_req || scrub_go);
  assign last       = state_q == ACCESS && cnt_q == LAST;
  assign rd_done    = last && wena_q == 2'b00;
  assign scrub_done = last && owner_q == SCRUB;

  extmem_scrubber #(
    .AW(AW),
    .SCRUB_IDLE(SCRUB_IDLE)
  ) u_scrub (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .scrub_en(scrub_en),
    .quiet(quiet),
    .grant(grant),
    .rd_done(rd_done),
    .scrub_done(scrub_done),
    .rd_addr(addr_q),
    .rd_data(extmemdin),
    .perr_clr(perr_clr),
    .scrub_go(scrub_go),
    .scrub_addr(scrub_addr),
    .perr_count(perr_count),
    .perr_addr(perr_addr)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    wena_d   = wena_q;
    enab_d   = enab_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    starve_d = r1_req ? starve_q : '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (r1_req && (!r0_req || starve_q == SMAX)) begin
          owner_d  = P1;
          addr_d   = r1_addr;
          dout_d   = r1_wdata;
          wena_d   = r1_wena;
          starve_d = '0;
        end else if (r0_req) begin
          owner_d  = P0;
          addr_d   = r0_addr;
          dout_d   = r0_wdata;
          wena_d   = r0_wena;
          starve_d = r1_req ? starve_q + 1'b1 : '0;
        end else if (scrub_go) begin
          owner_d = SCRUB;
          addr_d  = scrub_addr;
          dout_d  = '0;
          wena_d  = '0;
        end
        if (grant) begin
          enab_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (last) begin
          state_d = DONE;
          enab_d  = 1'b0;
          wena_d  = '0;
          // Writes hand back their own write data.
          if (owner_q == P0)
            rd0_d = rd_done ? extmemdin : dout_q;
          if (owner_q == P1)
            rd1_d = rd_done ? extmemdin : dout_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= P0;
      cnt_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      wena_q   <= '0;
      enab_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      wena_q   <= wena_d;
      enab_q   <= enab_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign r0_ack     = state_q == DONE && owner_q == P0;
  assign r1_ack     = state_q == DONE && owner_q == P1;
  assign r0_rdata   = rd0_q;
  assign r1_rdata   = rd1_q;
  assign extmemaddr = addr_q;
  assign extmemdout = dout_q;
  assign extmemwena = wena_q;
  assign extmemenab = enab_q;

endmodule

// File: tb/tb_extmem_arbiter.sv
// Scoreboard bench for extmem_arbiter: directed port traffic,
// starvation, scrub timing, reset abort and scrub wrap/parity.
module tb_extmem_arbiter;

  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  // Main instance, default parameters
  logic        r0_req, r1_req, scrub_en, perr_clr;
  logic [16:0] r0_addr, r1_addr;
  logic [1:0]  r0_wena, r1_wena;
  logic [17:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [17:0] r0_rdata, r1_rdata;
  logic [15:0] perr_count;
  logic [16:0] perr_addr, extmemaddr;
  logic [17:0] extmemdout, extmemdin;
  logic        extmemenab;
  logic [1:0]  extmemwena;

  extmem_arbiter u_dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wena(r0_wena),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wena(r1_wena),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .scrub_en(scrub_en), .perr_count(perr_count),
    .perr_addr(perr_addr), .perr_clr(perr_clr),
    .extmemaddr(extmemaddr), .extmemdout(extmemdout),
    .extmemdin(extmemdin), .extmemenab(extmemenab),
    .extmemwena(extmemwena)
  );

  // Small instance for scrub wrap-around
  logic        s_r0_req, s_r1_req, s_scrub_en, s_perr_clr;
  logic [3:0]  s_r0_addr, s_r1_addr;
  logic [1:0]  s_r0_wena, s_r1_wena;
  logic [17:0] s_r0_wdata, s_r1_wdata;
  logic        s_r0_ack, s_r1_ack;
  logic [17:0] s_r0_rdata, s_r1_rdata;
  logic [15:0] s_perr_count;
  logic [3:0]  s_perr_addr, s_addr;
  logic [17:0] s_dout, s_din;
  logic        s_enab;
  logic [1:0]  s_wena;

  extmem_arbiter #(.AW(4), .LAT(2), .STARVE(4), .SCRUB_IDLE(4)) u_sm (
    .CLOCK(CLOCK), .RESET(RESET),
    .r0_req(s_r0_req), .r0_addr(s_r0_addr), .r0_wena(s_r0_wena),
    .r0_wdata(s_r0_wdata), .r0_ack(s_r0_ack), .r0_rdata(s_r0_rdata),
    .r1_req(s_r1_req), .r1_addr(s_r1_addr), .r1_wena(s_r1_wena),
    .r1_wdata(s_r1_wdata), .r1_ack(s_r1_ack), .r1_rdata(s_r1_rdata),
    .scrub_en(s_scrub_en), .perr_count(s_perr_count),
    .perr_addr(s_perr_addr), .perr_clr(s_perr_clr),
    .extmemaddr(s_addr), .extmemdout(s_dout),
    .extmemdin(s_din), .extmemenab(s_enab),
    .extmemwena(s_wena)
  );

  // RAM models; 0x20100 has good parity in both bytes
  logic [17:0] mem0 [0:131071];
  logic [17:0] mem1 [0:15];

  initial begin
    for (int i = 0; i < 131072; i++) mem0[i] = 18'h20100;
    for (int i = 0; i < 16; i++) mem1[i] = 18'h20100;
    mem0[17'h00200] = 18'h00155;
    mem1[15] = 18'h00001;
  end

  always @(negedge CLOCK) begin
    extmemdin <= mem0[extmemaddr];
    s_din     <= mem1[s_addr];
  end

  always @(posedge CLOCK) begin
    if (extmemenab && extmemwena[1])
      mem0[extmemaddr][17:9] <= extmemdout[17:9];
    if (extmemenab && extmemwena[0])
      mem0[extmemaddr][8:0] <= extmemdout[8:0];
  end

  int checks = 0;
  int failures = 0;
  int qo[$];
  logic [17:0] q0[$];
  logic [17:0] q1[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops the expected owner and data
  always @(negedge CLOCK) begin
    if (!RESET && (r0_ack || r1_ack)) begin
      if (r0_ack && r1_ack) check("dual_ack", 1, 0);
      if (qo.size() == 0) begin
        check("unexpected_ack", {r1_ack, r0_ack}, 0);
      end else begin
        check("ack_order", r1_ack ? 1 : 0, qo.pop_front());
        if (r0_ack) begin
          if (q0.size() == 0) check("r0_q_empty", 1, 0);
          else check("r0_rdata", r0_rdata, q0.pop_front());
        end else begin
          if (q1.size() == 0) check("r1_q_empty", 1, 0);
          else check("r1_rdata", r1_rdata, q1.pop_front());
        end
      end
    end
    if (!RESET && (s_r0_ack || s_r1_ack))
      check("sm_ack", {s_r1_ack, s_r0_ack}, 0);
  end

  task automatic txn(input int p, input logic [16:0] a,
                     input logic [1:0] we, input logic [17:0] wd,
                     input logic [17:0] exp, input int lat);
    int n;
    qo.push_back(p);
    if (p == 0) begin
      q0.push_back(exp);
      r0_addr = a; r0_wena = we; r0_wdata = wd; r0_req = 1'b1;
    end else begin
      q1.push_back(exp);
      r1_addr = a; r1_wena = we; r1_wdata = wd; r1_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!(p == 0 ? r0_ack : r1_ack) && n < 100);
    r0_req = 1'b0;
    r1_req = 1'b0;
    check("txn_latency", n, lat);
  endtask

  task automatic wait_enab(output int n);
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!extmemenab && n < 300);
  endtask

  initial begin
    int n, acks;
    RESET = 1'b1;
    {r0_req, r1_req, scrub_en, perr_clr} = '0;
    r0_addr = '0; r1_addr = '0; r0_wena = '0; r1_wena = '0;
    r0_wdata = '0; r1_wdata = '0;
    {s_r0_req, s_r1_req, s_scrub_en, s_perr_clr} = '0;
    s_r0_addr = '0; s_r1_addr = '0; s_r0_wena = '0; s_r1_wena = '0;
    s_r0_wdata = '0; s_r1_wdata = '0;
    repeat (3) @(negedge CLOCK);
    check("rst_r0_ack", r0_ack, 0);
    check("rst_r1_ack", r1_ack, 0);
    check("rst_enab", extmemenab, 0);
    check("rst_wena", extmemwena, 0);
    check("rst_addr", extmemaddr, 0);
    check("rst_perr", perr_count, 0);
    check("rst_rdata", r0_rdata, 0);
    RESET = 1'b0;

    // Port-0 write then read
    @(negedge CLOCK);
    txn(0, 17'h00123, 2'b11, 18'h2AB55, 18'h2AB55, 3);
    @(negedge CLOCK);
    txn(0, 17'h00123, 2'b00, 18'h0, 18'h2AB55, 3);
    // Port-1 high-byte write over 0x00155
    @(negedge CLOCK);
    txn(1, 17'h00200, 2'b10, 18'h3FF00, 18'h3FF00, 3);
    @(negedge CLOCK);
    txn(1, 17'h00200, 2'b00, 18'h0, 18'h3FF55, 3);
    check("perr_after_rw", perr_count, 0);

    // Both ports requesting continuously
    @(negedge CLOCK);
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        qo.push_back(1);
        q1.push_back(18'h3FF55);
      end else begin
        qo.push_back(0);
        q0.push_back(18'h2AB55);
      end
    end
    r0_addr = 17'h00123; r0_wena = 2'b00;
    r1_addr = 17'h00200; r1_wena = 2'b00;
    r0_req = 1'b1; r1_req = 1'b1;
    n = 0; acks = 0;
    while (acks < 10 && n < 200) begin
      @(negedge CLOCK);
      n++;
      if (r0_ack || r1_ack) acks++;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("burst_acks", acks, 10);
    check("burst_cycles", n, 39);

    // Scrub, then a port-0 request arriving mid-scrub
    @(negedge CLOCK);
    scrub_en = 1'b1;
    wait_enab(n);
    check("scrub_delay", n, 65);
    check("scrub_addr0", extmemaddr, 0);
    check("scrub_wena", extmemwena, 0);
    @(negedge CLOCK);
    txn(0, 17'h00123, 2'b00, 18'h0, 18'h2AB55, 5);
    wait_enab(n);
    check("scrub_restart", n, 66);
    check("scrub_addr1", extmemaddr, 1);
    scrub_en = 1'b0;
    repeat (4) @(negedge CLOCK);
    check("perr_scrub", perr_count, 0);

    // Reset in the middle of an access
    r0_addr = 17'h00123; r0_wena = 2'b00; r0_req = 1'b1;
    wait_enab(n);
    check("abort_grant", n, 1);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("abort_enab", extmemenab, 0);
    check("abort_ack", r0_ack, 0);
    check("abort_perr", perr_count, 0);
    r0_req = 1'b0;
    RESET = 1'b0;
    scrub_en = 1'b1;
    wait_enab(n);
    check("abort_scrub_delay", n, 65);
    check("abort_ptr", extmemaddr, 0);
    scrub_en = 1'b0;
    repeat (4) @(negedge CLOCK);

    // Scrub wrap on the small instance
    s_scrub_en = 1'b1;
    n = 0;
    while (s_perr_count == 0 && n < 2000) begin
      @(negedge CLOCK);
      n++;
    end
    check("wrap_perr_count", s_perr_count, 1);
    check("wrap_perr_addr", s_perr_addr, 4'hF);
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!s_enab && n < 100);
    check("wrap_next_addr", s_addr, 0);
    check("wrap_wena", s_wena, 0);
    s_scrub_en = 1'b0;
    s_perr_clr = 1'b1;
    @(negedge CLOCK);
    s_perr_clr = 1'b0;
    check("clr_count", s_perr_count, 0);
    check("clr_addr", s_perr_addr, 0);
    repeat (4) @(negedge CLOCK);
    check("sm_dout", s_dout, 0);
    check("sm_rdata", {s_r0_rdata, s_r1_rdata}, 0);
    check("final_perr", perr_count, 0);
    check("queue_empty", qo.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
